// File: rtl/mul_share_arbiter.sv
// Shares one pipelined signed 8x8 multiplier among NREQ tagged requesters.
// Round-robin grant by default; define MUL_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [15:0]       res_p,
  input  logic              res_ready,
  output logic              busy
);

  logic                 ce_s;
  logic                 hs_s;
  logic                 gnt_found_s;
  logic [IDW-1:0]       gnt_idx_s;
  int                   dist_s;
  int                   best_s;
  logic signed [7:0]    a_sel_s;
  logic signed [7:0]    b_sel_s;
  logic signed [7:0]    a1_r;
  logic signed [7:0]    b1_r;
  logic [LAT:1]         v_r;
  logic [IDW-1:0]       id_r [1:LAT];
  logic signed [15:0]   p_r  [2:LAT];
`ifndef MUL_ARB_FIXED_PRIORITY_EN
  logic [IDW-1:0]       ptr_r;
`endif

  // A stalled result freezes every stage, the grant pointer and acceptance.
  assign ce_s = !res_valid || res_ready;
  assign hs_s = gnt_found_s && ce_s;
  assign busy = (|v_r) || res_valid;

  // Grant: requester with the smallest rotational distance from the pointer wins.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    best_s      = NREQ;
    dist_s      = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef MUL_ARB_FIXED_PRIORITY_EN
      dist_s = i;
`else
      dist_s = i - int'(ptr_r);
      if (dist_s < 0) begin
        dist_s = dist_s + NREQ;
      end else begin
        dist_s = dist_s;
      end
`endif
      if (req_valid[i] && (dist_s < best_s)) begin
        best_s      = dist_s;
        gnt_idx_s   = IDW'(i);
        gnt_found_s = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

  // One-hot acceptance and operand select for the granted requester.
  always_comb begin
    req_ready = '0;
    a_sel_s   = 8'sd0;
    b_sel_s   = 8'sd0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = hs_s && (gnt_idx_s == IDW'(i));
      if (gnt_idx_s == IDW'(i)) begin
        a_sel_s = req_a[8*i +: 8];
        b_sel_s = req_b[8*i +: 8];
      end else begin
        a_sel_s = a_sel_s;
        b_sel_s = b_sel_s;
      end
    end
  end

  // Operand stage, product stage, delay stages and the registered result.
  always_ff @(posedge CLK) begin
    if (rst) begin
      v_r       <= '0;
      a1_r      <= 8'sd0;
      b1_r      <= 8'sd0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_p     <= 16'h0000;
      for (int s = 1; s <= LAT; s++) begin
        id_r[s] <= '0;
      end
      for (int s = 2; s <= LAT; s++) begin
        p_r[s] <= 16'sd0;
      end
    end else if (ce_s) begin
      v_r[1] <= hs_s;
      if (hs_s) begin
        a1_r    <= a_sel_s;
        b1_r    <= b_sel_s;
        id_r[1] <= gnt_idx_s;
      end
      // Sign-extend before multiplying so the low 16 bits are the exact product.
      v_r[2]  <= v_r[1];
      id_r[2] <= id_r[1];
      p_r[2]  <= 16'(a1_r) * 16'(b1_r);
      for (int s = 3; s <= LAT; s++) begin
        v_r[s]  <= v_r[s-1];
        id_r[s] <= id_r[s-1];
        p_r[s]  <= p_r[s-1];
      end
      res_valid <= v_r[LAT];
      res_id    <= id_r[LAT];
      res_p     <= p_r[LAT];
    end
  end

`ifndef MUL_ARB_FIXED_PRIORITY_EN
  // Rotate priority to just past the requester served on this edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (hs_s) begin
      ptr_r <= (gnt_idx_s == IDW'(NREQ-1)) ? '0 : gnt_idx_s + IDW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter against a queue-based transaction model.
module tb_mul_share_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int IDW  = 2;

  logic              CLK;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [15:0]       res_p;
  logic              res_ready;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int op_a [NREQ];
  int op_b [NREQ];

  // Model: each accepted op carries the number of advancing edges since issue.
  typedef struct {int id; int p; int age;} op_t;
  op_t q[$];
  int  ptr_m;

  mul_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_p(res_p),
    .res_ready(res_ready), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

  function automatic int m_grant();
    for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_ARB_FIXED_PRIORITY_EN
      int idx = k;
`else
      int idx = (ptr_m + k) % NREQ;
`endif
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_res_valid();
    return (q.size() > 0) && (q[0].age == LAT);
  endfunction

  function automatic bit m_ce();
    return !m_res_valid() || res_ready;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    logic [NREQ-1:0] r = '0;
    int g = m_grant();
    if (m_ce() && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model with the inputs the DUT is about to sample, then clock.
  task automatic tick();
    int  g;
    op_t o;
    if (rst) begin
      q.delete();
      ptr_m = 0;
    end else if (m_ce()) begin
      g = m_grant();
      if (m_res_valid()) q.delete(0);
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (g >= 0) begin
        o.id = g; o.p = op_a[g] * op_b[g]; o.age = 0;
        q.push_back(o);
        ptr_m = (g + 1) % NREQ;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(op_a[i]);
      req_b[8*i +: 8] = 8'(op_b[i]);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = int'($urandom_range(255)) - 128;
      op_b[i] = int'($urandom_range(255)) - 128;
    end
    set_ops();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; res_ready = 1'b1;
    tick(); tick();
    @(negedge CLK);
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    tests_run++; if (res_p !== 16'h0000 || res_id !== '0) begin tests_failed++; $display("FAIL reset_data got p=%h id=%0d exp p=0 id=0", res_p, res_id); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (req_ready !== '0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    op_a[1] = 5; op_b[1] = -3; set_ops();
    req_valid = 4'b0010; res_ready = 1'b1;
    @(negedge CLK);
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    for (int e = 0; e <= LAT; e++) begin
      @(negedge CLK);
      tests_run++; if (res_valid !== (e == LAT)) begin tests_failed++; $display("FAIL single_latency edge+%0d got=%b exp=%b", e, res_valid, (e == LAT)); end
      if (e < LAT) tick();
    end
    tests_run++; if (res_id !== 2'd1 || res_p !== 16'hFFF1) begin tests_failed++; $display("FAIL single_result got id=%0d p=%h exp id=1 p=fff1", res_id, res_p); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_hold got=%b exp=1", busy); end
    tick();
    @(negedge CLK);
    tests_run++; if (busy !== 1'b0 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain got busy=%b valid=%b exp 0 0", busy, res_valid); end
    tick();
  endtask

`ifndef MUL_ARB_FIXED_PRIORITY_EN
  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = '1; res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_ops();
      @(negedge CLK);
      tests_run++; if (req_ready !== 4'(1 << (c % NREQ))) begin tests_failed++; $display("FAIL rr_grant c=%0d got=%b exp=%0d", c, req_ready, c % NREQ); end
      tests_run++; if (res_valid !== (c >= LAT + 1)) begin tests_failed++; $display("FAIL rr_valid c=%0d got=%b exp=%b", c, res_valid, (c >= LAT + 1)); end
      if (c >= LAT + 1 && q.size() > 0) begin
        tests_run++; if (res_id !== IDW'((c - LAT - 1) % NREQ) || res_p !== 16'(q[0].p)) begin tests_failed++; $display("FAIL rr_result c=%0d got id=%0d p=%h exp id=%0d p=%h", c, res_id, res_p, (c - LAT - 1) % NREQ, 16'(q[0].p)); end
      end
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < LAT + 2; c++) tick();
  endtask
`else
  task automatic test_fixed_priority();
    req_valid = 4'b0101; res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rand_ops();
      @(negedge CLK);
      tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL fixed_grant c=%0d got=%b exp=0001", c, req_ready); end
      tick();
    end
    req_valid = 4'b0100;
    @(negedge CLK);
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL fixed_grant_low got=%b exp=0100", req_ready); end
    req_valid = '0;
    for (int c = 0; c < LAT + 8; c++) tick();
  endtask
`endif

  task automatic test_boundary();
    logic [15:0]     exp_tab [3];
    logic [NREQ-1:0] done;
    int              got;
    exp_tab[0] = 16'h4000; exp_tab[1] = 16'hC080; exp_tab[2] = 16'h0000;
    op_a[0] = -128; op_b[0] = -128;
    op_a[1] = 127;  op_b[1] = -128;
    op_a[2] = 0;    op_b[2] = int'($urandom_range(255)) - 128;
    set_ops();
    req_valid = 4'b0111; res_ready = 1'b1; got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (res_valid) begin
        got++;
        tests_run++; if (res_id > 2'd2 || res_p !== exp_tab[res_id]) begin tests_failed++; $display("FAIL boundary id=%0d got=%h", res_id, res_p); end
      end
      done = req_ready;
      tick();
      req_valid = req_valid & ~done;
    end
    tests_run++; if (got != 3) begin tests_failed++; $display("FAIL boundary_count got=%0d exp=3", got); end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    req_valid = '1; res_ready = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      rand_ops();
      @(negedge CLK);
      if (res_valid) seen = 1'b1; else tick();
    end
    tests_run++; if (!seen || q.size() == 0) begin tests_failed++; $display("FAIL bp_first_result got=%b exp=1", seen); end
    if (q.size() > 0) begin
      res_ready = 1'b0;
      #1;
      for (int s = 0; s < 4; s++) begin
        tests_run++; if (res_valid !== 1'b1 || res_id !== IDW'(q[0].id) || res_p !== 16'(q[0].p)) begin tests_failed++; $display("FAIL bp_hold s=%0d got v=%b id=%0d p=%h exp id=%0d p=%h", s, res_valid, res_id, res_p, q[0].id, 16'(q[0].p)); end
        tests_run++; if (req_ready !== '0 || busy !== 1'b1) begin tests_failed++; $display("FAIL bp_freeze s=%0d got ready=%b busy=%b exp 0 1", s, req_ready, busy); end
        if (s < 3) begin tick(); @(negedge CLK); end
      end
      res_ready = 1'b1;
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      if (c == 8) req_valid = '0;
      rand_ops();
      @(negedge CLK);
      tests_run++; if (res_valid !== m_res_valid() || req_ready !== m_ready()) begin tests_failed++; $display("FAIL bp_resume c=%0d got v=%b rdy=%b exp v=%b rdy=%b", c, res_valid, req_ready, m_res_valid(), m_ready()); end
      if (m_res_valid()) begin
        tests_run++; if (res_id !== IDW'(q[0].id) || res_p !== 16'(q[0].p)) begin tests_failed++; $display("FAIL bp_result c=%0d got id=%0d p=%h exp id=%0d p=%h", c, res_id, res_p, q[0].id, 16'(q[0].p)); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    req_valid = '1; res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin rand_ops(); tick(); end
    @(negedge CLK);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = '0;
    @(negedge CLK);
    tests_run++; if (res_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset got v=%b busy=%b exp 0 0", res_valid, busy); end
    for (int c = 0; c < LAT + 3; c++) begin
      tick();
      @(negedge CLK);
      tests_run++; if (res_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_stale c=%0d got v=%b busy=%b exp 0 0", c, res_valid, busy); end
    end
    req_valid = '1;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = (c < 390) ? NREQ'($urandom_range((1 << NREQ) - 1)) : '0;
      res_ready = (c < 390) ? ($urandom_range(3) != 0) : 1'b1;
      rand_ops();
      @(negedge CLK);
      tests_run++; if (res_valid !== m_res_valid()) begin tests_failed++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, res_valid, m_res_valid()); end
      if (m_res_valid()) begin
        tests_run++; if (res_id !== IDW'(q[0].id) || res_p !== 16'(q[0].p)) begin tests_failed++; $display("FAIL rand_result c=%0d got id=%0d p=%h exp id=%0d p=%h", c, res_id, res_p, q[0].id, 16'(q[0].p)); end
      end
      tests_run++; if (req_ready !== m_ready()) begin tests_failed++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, m_ready()); end
      tests_run++; if (busy !== (q.size() > 0)) begin tests_failed++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, (q.size() > 0)); end
      tick();
    end
    @(negedge CLK);
    tests_run++; if (q.size() != 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rand_drain got busy=%b model_left=%0d exp 0 0", busy, q.size()); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1; ptr_m = 0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = 0; op_b[i] = 0; end
    test_reset();
    test_single_op();
`ifdef MUL_ARB_FIXED_PRIORITY_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_boundary();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
